sprite_fetch: RTL

- Sits directly upstream of the background/sprite display multiplexer. It consumes the VGA timing counters and produces the 16-bit sprite word (RGB[15:4], alpha[3:0]) and a matching display flag.
- Holds the sprite's screen position and updates it once per frame from four debounced direction buttons, clamped to the visible area.
- Generates the address for the sprite ROM, which has a synchronous read, and pipelines the video-on flag so the sprite word and the display flag stay aligned.

---
 rtl/sprite_pkg.sv | 45 ++++
 rtl/sprite_pos_ctrl.sv | 65 ++++++
 rtl/sprite_fetch.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// ----------------------------------------------------------------------------
// sprite_pkg
//   Shared types and default geometry for the sprite fetch path.
//   - H_ACTIVE / V_ACTIVE : visible raster size
//   - SPRITE_W / SPRITE_H : sprite bitmap size
//   - coord_t             : 10-bit screen coordinate
//   - pixel_rgba_t        : 16-bit sprite word, rgb[11:0] then alpha[3:0]
//   - step_clamp()        : one-axis move by +/-step, clamped to [0, lim]
// ----------------------------------------------------------------------------
package sprite_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int SPRITE_W = 32;
    localparam int SPRITE_H = 32;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic [11:0] rgb;
        logic [3:0]  alpha;
    } pixel_rgba_t;

    // inc/dec both set (or both clear) cancel out. The decrement compares
    // before subtracting so a position below 'step' lands on 0 instead of
    // wrapping to the far edge.
    function automatic coord_t step_clamp(
        input coord_t      pos,
        input logic        inc,
        input logic        dec,
        input logic [10:0] step,
        input logic [10:0] lim
    );
        logic [10:0] w_up;
        coord_t      w_dn;
        w_up = {1'b0, pos} + step;
        w_dn = pos - step[9:0];
        step_clamp = pos;
        if (inc && !dec)
            step_clamp = (w_up > lim) ? lim[9:0] : w_up[9:0];
        else if (dec && !inc)
            step_clamp = ({1'b0, pos} < step) ? '0 : w_dn;
    endfunction

endpackage

// File: rtl/sprite_pos_ctrl.sv
// ----------------------------------------------------------------------------
// sprite_pos_ctrl
//   Holds the sprite's top-left position and moves it once per frame from
//   the four direction buttons, clamped so the whole sprite stays visible.
//
//   Ports
//     clk, reset          pixel clock, async active-high reset
//     hcount, vcount      raster counters (used only for the frame tick)
//     btn_up/down/left/right  debounced, synchronised, level-sensitive
//     pos_x, pos_y        current top-left corner of the sprite
// ----------------------------------------------------------------------------
module sprite_pos_ctrl #(
    parameter int H_ACTIVE = sprite_pkg::H_ACTIVE,
    parameter int V_ACTIVE = sprite_pkg::V_ACTIVE,
    parameter int SPRITE_W = sprite_pkg::SPRITE_W,
    parameter int SPRITE_H = sprite_pkg::SPRITE_H,
    parameter int STEP     = 2,
    parameter int START_X  = 304,
    parameter int START_Y  = 224
) (
    input  logic               clk,
    input  logic               reset,
    input  sprite_pkg::coord_t hcount,
    input  sprite_pkg::coord_t vcount,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    output sprite_pkg::coord_t pos_x,
    output sprite_pkg::coord_t pos_y
);
    import sprite_pkg::*;

    localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - SPRITE_W);
    localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - SPRITE_H);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam coord_t      V_TICK = coord_t'(V_ACTIVE);

    logic   w_frame_tick;
    coord_t w_x_next;
    coord_t w_y_next;
    coord_t r_pos_x;
    coord_t r_pos_y;

    // First pixel of the first blanking line: moving here means the
    // position never changes while the sprite is being drawn.
    assign w_frame_tick = (hcount == '0) && (vcount == V_TICK);

    assign w_x_next = step_clamp(r_pos_x, btn_right, btn_left, STEP_W, X_MAX);
    assign w_y_next = step_clamp(r_pos_y, btn_down,  btn_up,   STEP_W, Y_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pos_x <= coord_t'(START_X);
            r_pos_y <= coord_t'(START_Y);
        end else if (w_frame_tick) begin
            r_pos_x <= w_x_next;
            r_pos_y <= w_y_next;
        end
    end

    assign pos_x = r_pos_x;
    assign pos_y = r_pos_y;

endmodule

// File: rtl/sprite_fetch.sv
// ----------------------------------------------------------------------------
// sprite_fetch
//   Turns the VGA raster position into a sprite ROM address and returns the
//   sprite word two clocks later, together with a matching display flag.
//   Outside the sprite box (or in blanking) the word is 0, so alpha is 0
//   and the downstream mux shows the background.
//
//   Ports
//     clk, reset          pixel clock, async active-high reset
//     hcount, vcount      raster position from the VGA controller
//     video_on            high in the visible region
//     btn_*               direction buttons, sampled on the frame tick
//     rom_addr            registered sprite ROM address (this register is
//                         the ROM's address register; rom_data follows it)
//     rom_data            ROM word for rom_addr
//     sprite              sprite word, 2 clocks after the raster inputs
//     display             video_on delayed by the same 2 clocks
//     pos_x, pos_y        sprite top-left corner
// ----------------------------------------------------------------------------
module sprite_fetch #(
    parameter int H_ACTIVE = sprite_pkg::H_ACTIVE,
    parameter int V_ACTIVE = sprite_pkg::V_ACTIVE,
    parameter int SPRITE_W = sprite_pkg::SPRITE_W,
    parameter int SPRITE_H = sprite_pkg::SPRITE_H,
    parameter int ADDR_W   = 10,
    parameter int STEP     = 2,
    parameter int START_X  = 304,
    parameter int START_Y  = 224
) (
    input  logic               clk,
    input  logic               reset,
    input  sprite_pkg::coord_t hcount,
    input  sprite_pkg::coord_t vcount,
    input  logic               video_on,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [15:0]        rom_data,
    output logic [15:0]        sprite,
    output logic               display,
    output sprite_pkg::coord_t pos_x,
    output sprite_pkg::coord_t pos_y
);
    import sprite_pkg::*;

    localparam int          W_LOG2 = $clog2(SPRITE_W);
    localparam bit          W_POW2 = (SPRITE_W == (1 << W_LOG2));
    localparam logic [10:0] SW_11  = 11'(SPRITE_W);
    localparam logic [10:0] SH_11  = 11'(SPRITE_H);

    coord_t              w_pos_x;
    coord_t              w_pos_y;
    logic [10:0]         w_h;
    logic [10:0]         w_v;
    logic [10:0]         w_px;
    logic [10:0]         w_py;
    logic                w_in_box;
    coord_t              w_dx;
    coord_t              w_dy;
    logic [ADDR_W-1:0]   w_addr;

    logic [ADDR_W-1:0]   r_rom_addr;
    logic                r_box_d1;
    logic                r_von_d1;
    pixel_rgba_t         r_sprite;
    logic                r_display;

    sprite_pos_ctrl #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .STEP     (STEP),
        .START_X  (START_X),
        .START_Y  (START_Y)
    ) u_pos (
        .clk       (clk),
        .reset     (reset),
        .hcount    (hcount),
        .vcount    (vcount),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .pos_x     (w_pos_x),
        .pos_y     (w_pos_y)
    );

    // ---- stage 0: box test and address ----
    // 11-bit compares: pos + SIZE can exceed 1023 near the bottom/right.
    assign w_h  = {1'b0, hcount};
    assign w_v  = {1'b0, vcount};
    assign w_px = {1'b0, w_pos_x};
    assign w_py = {1'b0, w_pos_y};

    assign w_in_box = video_on
                   && (w_h >= w_px) && (w_h < w_px + SW_11)
                   && (w_v >= w_py) && (w_v < w_py + SH_11);

    // Offsets are only meaningful inside the box; outside, the address is
    // forced to 0 in stage 1, so wrap-around here is harmless.
    assign w_dx = hcount - w_pos_x;
    assign w_dy = vcount - w_pos_y;

    generate
        if (W_POW2) begin : g_addr_shift
            assign w_addr = (ADDR_W'(w_dy) << W_LOG2) + ADDR_W'(w_dx);
        end else begin : g_addr_mul
            assign w_addr = ADDR_W'(w_dy) * ADDR_W'(SPRITE_W) + ADDR_W'(w_dx);
        end
    endgenerate

    // ---- stage 1: ROM address + flags; stage 2: ROM word + display ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rom_addr <= '0;
            r_box_d1   <= 1'b0;
            r_von_d1   <= 1'b0;
            r_sprite   <= '0;
            r_display  <= 1'b0;
        end else begin
            r_rom_addr <= w_in_box ? w_addr : '0;
            r_box_d1   <= w_in_box;
            r_von_d1   <= video_on;
            r_sprite   <= r_box_d1 ? pixel_rgba_t'(rom_data) : '0;
            r_display  <= r_von_d1;
        end
    end

    assign rom_addr = r_rom_addr;
    assign sprite   = r_sprite;
    assign display  = r_display;
    assign pos_x    = w_pos_x;
    assign pos_y    = w_pos_y;

endmodule
